// File: rtl/pv_ipv_calc_if.sv
// Operand/result bundle between the diode-exponent stage, this block and the Newton controller.
interface pv_ipv_calc_if #(parameter int SINGLE = 32);
  logic              sta;
  logic [SINGLE-1:0] X;
  logic [SINGLE-1:0] Vd;
  logic [SINGLE-1:0] I0;
  logic [SINGLE-1:0] Iph;
  logic [SINGLE-1:0] Gsh;
  logic [SINGLE-1:0] Id;
  logic [SINGLE-1:0] Ipv;
  logic              busy;
  logic              done_sig;
  logic              ovr_err;

  modport master (output sta, X, Vd, I0, Iph, Gsh,
                  input  Id, Ipv, busy, done_sig, ovr_err);
  modport slave  (input  sta, X, Vd, I0, Iph, Gsh,
                  output Id, Ipv, busy, done_sig, ovr_err);
endinterface

// File: rtl/pv_ipv_calc.sv
// Ipv = Iph - I0*X - Vd*Gsh in fp32 on one shared multiplier and one shared adder.
// Result and done_sig appear 3+MUL_LAT+2*ADD_LAT clocks after sta; sta while busy is dropped and flagged.

module Multiplier_nodsp #(
  parameter int LAT = 5
) (
  input  logic        aclr,
  input  logic        clk,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);
  logic [47:0] w_prod;
  logic [9:0]  w_e;
  logic [7:0]  w_eb;
  logic [22:0] w_man;
  logic        w_grd, w_stk, w_inc, w_sign;
  logic [30:0] w_mag;
  logic [31:0] w_res;
  logic [31:0] r_pipe [LAT];

  always_comb begin
    w_sign = dataa[31] ^ datab[31];
    w_prod = {24'b0, 1'b1, dataa[22:0]} * {24'b0, 1'b1, datab[22:0]};
    if (w_prod[47]) begin
      w_man = w_prod[46:24];
      w_grd = w_prod[23];
      w_stk = |w_prod[22:0];
      w_e   = {2'b0, dataa[30:23]} + {2'b0, datab[30:23]} + 10'd1;
    end else begin
      w_man = w_prod[45:23];
      w_grd = w_prod[22];
      w_stk = |w_prod[21:0];
      w_e   = {2'b0, dataa[30:23]} + {2'b0, datab[30:23]};
    end
    w_eb  = 8'(w_e - 10'd127);
    w_inc = w_grd & (w_stk | w_man[0]);
    w_mag = {w_eb, w_man} + {30'b0, w_inc};
    // Denormal inputs/results flush to zero, exponent overflow saturates to infinity.
    if (dataa[30:23] == 8'd0 || datab[30:23] == 8'd0 || w_e <= 10'd127)
      w_res = {w_sign, 31'b0};
    else if (w_e >= 10'd382)
      w_res = {w_sign, 8'hff, 23'b0};
    else
      w_res = {w_sign, w_mag};
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_res;
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign result = r_pipe[LAT-1];
endmodule

module Adder_nodsp #(
  parameter int LAT = 7
) (
  input  logic        aclr,
  input  logic        add_sub,
  input  logic        clk,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);
  logic        w_bs, w_big_s, w_sml_s;
  logic [7:0]  w_big_e, w_sml_e, w_d, w_eo;
  logic [22:0] w_big_f, w_sml_f;
  logic [26:0] w_big_m, w_sml_m, w_aln, w_n;
  logic [5:0]  w_sh;
  logic [53:0] w_ext;
  logic [27:0] w_sum;
  logic [4:0]  w_lz;
  logic        w_fnd, w_inc;
  logic [9:0]  w_ne;
  logic [30:0] w_mag;
  logic [31:0] w_res;
  logic [31:0] r_pipe [LAT];

  always_comb begin
    // add_sub=1 adds, add_sub=0 subtracts datab.
    w_bs = datab[31] ^ ~add_sub;
    if (dataa[30:0] >= datab[30:0]) begin
      w_big_s = dataa[31]; w_big_e = dataa[30:23]; w_big_f = dataa[22:0];
      w_sml_s = w_bs;      w_sml_e = datab[30:23]; w_sml_f = datab[22:0];
    end else begin
      w_big_s = w_bs;      w_big_e = datab[30:23]; w_big_f = datab[22:0];
      w_sml_s = dataa[31]; w_sml_e = dataa[30:23]; w_sml_f = dataa[22:0];
    end
    w_big_m = (w_big_e == 8'd0) ? 27'd0 : {1'b1, w_big_f, 3'b000};
    w_sml_m = (w_sml_e == 8'd0) ? 27'd0 : {1'b1, w_sml_f, 3'b000};
    w_d     = w_big_e - w_sml_e;
    w_sh    = (w_d > 8'd31) ? 6'd31 : w_d[5:0];
    w_ext   = {w_sml_m, 27'b0} >> w_sh;
    w_aln   = w_ext[53:27] | {26'b0, |w_ext[26:0]};
    if (w_big_s == w_sml_s) w_sum = {1'b0, w_big_m} + {1'b0, w_aln};
    else                    w_sum = {1'b0, w_big_m} - {1'b0, w_aln};

    w_lz  = 5'd0;
    w_fnd = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!w_fnd) begin
        if (w_sum[i]) w_fnd = 1'b1;
        else          w_lz  = w_lz + 5'd1;
      end
    end

    if (w_sum[27]) begin
      w_n  = w_sum[27:1] | {26'b0, w_sum[0]};
      w_ne = {2'b0, w_big_e} + 10'd1;
    end else begin
      w_n  = w_sum[26:0] << w_lz;
      w_ne = {2'b0, w_big_e} - {5'b0, w_lz};
    end
    w_eo  = w_ne[7:0];
    w_inc = w_n[2] & ((|w_n[1:0]) | w_n[3]);
    w_mag = {w_eo, w_n[25:3]} + {30'b0, w_inc};

    if (w_sum == 28'd0 || (!w_sum[27] && {5'b0, w_lz} >= {2'b0, w_big_e}))
      w_res = 32'd0;
    else if (w_ne >= 10'd255)
      w_res = {w_big_s, 8'hff, 23'b0};
    else
      w_res = {w_big_s, w_mag};
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_res;
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign result = r_pipe[LAT-1];
endmodule

module pv_ipv_calc #(
  parameter int SINGLE  = 32,
  parameter int MUL_LAT = 5,
  parameter int ADD_LAT = 7
) (
  input  logic          clk,
  input  logic          rst,
  pv_ipv_calc_if.slave  bus
);
  typedef enum logic [3:0] {
    IDLE, MUL_A, MUL_B, WAIT_M, ADD1, WAIT_A1, ADD2, WAIT_A2, OUT
  } state_t;

  localparam logic [3:0] MUL_WAIT  = 4'(MUL_LAT - 1);
  localparam logic [3:0] ADD_WAIT1 = 4'(ADD_LAT - 1);
  localparam logic [3:0] ADD_WAIT2 = 4'(ADD_LAT);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [SINGLE-1:0] r_x, r_vd, r_i0, r_iph, r_gsh;
  logic [SINGLE-1:0] r_id_prod, r_ish_prod, r_id, r_ipv;
  logic              r_busy, r_done, r_ovr;

  logic              w_aclr;
  logic [SINGLE-1:0] w_mul_a, w_mul_b, w_mul_res;
  logic [SINGLE-1:0] w_add_a, w_add_b, w_add_res;

  assign w_aclr = ~rst;

  // ADD2 chains straight off the adder output, so T1 never needs its own register.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    w_add_a = '0;
    w_add_b = '0;
    case (r_state)
      MUL_A:   begin w_mul_a = r_i0;      w_mul_b = r_x;        end
      MUL_B:   begin w_mul_a = r_vd;      w_mul_b = r_gsh;      end
      ADD1:    begin w_add_a = r_iph;     w_add_b = r_id_prod;  end
      ADD2:    begin w_add_a = w_add_res; w_add_b = r_ish_prod; end
      default: ;
    endcase
  end

  Multiplier_nodsp #(.LAT(MUL_LAT)) u_mul (
    .aclr   (w_aclr),
    .clk    (clk),
    .dataa  (w_mul_a),
    .datab  (w_mul_b),
    .result (w_mul_res)
  );

  Adder_nodsp #(.LAT(ADD_LAT)) u_add (
    .aclr    (w_aclr),
    .add_sub (1'b0),
    .clk     (clk),
    .dataa   (w_add_a),
    .datab   (w_add_b),
    .result  (w_add_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_x        <= '0;
      r_vd       <= '0;
      r_i0       <= '0;
      r_iph      <= '0;
      r_gsh      <= '0;
      r_id_prod  <= '0;
      r_ish_prod <= '0;
      r_id       <= '0;
      r_ipv      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.sta && r_state != IDLE) r_ovr <= 1'b1;
      case (r_state)
        IDLE: if (bus.sta) begin
          r_x     <= bus.X;
          r_vd    <= bus.Vd;
          r_i0    <= bus.I0;
          r_iph   <= bus.Iph;
          r_gsh   <= bus.Gsh;
          r_busy  <= 1'b1;
          r_state <= MUL_A;
        end
        MUL_A: r_state <= MUL_B;
        MUL_B: begin
          r_cnt   <= MUL_WAIT;
          r_state <= WAIT_M;
        end
        WAIT_M: if (r_cnt == 4'd1) begin
          r_id_prod <= w_mul_res;
          r_state   <= ADD1;
        end else r_cnt <= r_cnt - 4'd1;
        // The Ish product emerges exactly one clock after Id, i.e. while ADD1 issues.
        ADD1: begin
          r_ish_prod <= w_mul_res;
          r_cnt      <= ADD_WAIT1;
          r_state    <= WAIT_A1;
        end
        WAIT_A1: if (r_cnt == 4'd1) r_state <= ADD2;
                 else r_cnt <= r_cnt - 4'd1;
        ADD2: begin
          r_cnt   <= ADD_WAIT2;
          r_state <= WAIT_A2;
        end
        WAIT_A2: if (r_cnt == 4'd1) begin
          r_id    <= r_id_prod;
          r_ipv   <= w_add_res;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= OUT;
        end else r_cnt <= r_cnt - 4'd1;
        OUT:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Id       = r_id;
  assign bus.Ipv      = r_ipv;
  assign bus.busy     = r_busy;
  assign bus.done_sig = r_done;
  assign bus.ovr_err  = r_ovr;
endmodule

// File: tb/tb_pv_ipv_calc.sv
// Scoreboarded bench for pv_ipv_calc: directed fp32 vectors with exactly representable results.
module tb_pv_ipv_calc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pv_ipv_calc_if #(.SINGLE(32)) bus ();

  pv_ipv_calc #(.SINGLE(32), .MUL_LAT(5), .ADD_LAT(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] x, vd, i0, iph, gsh, id, ipv;
  } vec_t;

  typedef struct {
    logic [31:0] id;
    logic [31:0] ipv;
    int          due;
  } want_t;

  // {X, Vd, I0, Iph, Gsh, expected Id, expected Ipv}
  vec_t vecs [7] = '{
    '{32'h40000000, 32'h41200000, 32'h3f000000, 32'h41000000, 32'h3e000000, 32'h3f800000, 32'h40b80000},
    '{32'h00000000, 32'h41200000, 32'h3f000000, 32'h41000000, 32'h00000000, 32'h00000000, 32'h41000000},
    '{32'h3f800000, 32'h40800000, 32'h40000000, 32'h41200000, 32'h3f000000, 32'h40000000, 32'h40c00000},
    '{32'h40400000, 32'h40000000, 32'h3e800000, 32'h3f800000, 32'h3e800000, 32'h3f400000, 32'hbe800000},
    '{32'h3fc00000, 32'h40a00000, 32'h3fc00000, 32'h40a00000, 32'h3e800000, 32'h40100000, 32'h3fc00000},
    '{32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000, 32'hbf800000},
    '{32'h40e00000, 32'h41a00000, 32'h3d800000, 32'h40400000, 32'h3c800000, 32'h3ee00000, 32'h40100000}
  };

  want_t sb [$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one sta pulse in the current cycle; scramble inputs afterwards.
  task automatic start(input int idx, input bit expect_result);
    if (expect_result)
      sb.push_back('{vecs[idx].id, vecs[idx].ipv, cyc + 22});
    bus.sta = 1'b1;
    bus.X   = vecs[idx].x;
    bus.Vd  = vecs[idx].vd;
    bus.I0  = vecs[idx].i0;
    bus.Iph = vecs[idx].iph;
    bus.Gsh = vecs[idx].gsh;
    tick(1);
    bus.sta = 1'b0;
    bus.X   = $urandom;
    bus.Vd  = $urandom;
    bus.I0  = $urandom;
    bus.Iph = $urandom;
    bus.Gsh = $urandom;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (sb.size() != 0 && k < bound) begin
      tick(1);
      k++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    tick(1);
  endtask

  // Monitor: every done_sig must match the oldest outstanding expectation.
  initial begin
    want_t w;
    forever begin
      @(negedge clk);
      if (bus.done_sig === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done at cycle %0d: got done_sig=1, expected 0", cyc);
        end else begin
          w = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(w.due));
          check("Id", bus.Id, w.id);
          check("Ipv", bus.Ipv, w.ipv);
        end
      end
    end
  end

  initial begin
    bus.sta = 1'b0;
    bus.X   = '0;
    bus.Vd  = '0;
    bus.I0  = '0;
    bus.Iph = '0;
    bus.Gsh = '0;

    // Reset state
    tick(2);
    check("rst_Id", bus.Id, 32'h0);
    check("rst_Ipv", bus.Ipv, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_done", {31'b0, bus.done_sig}, 32'h0);
    check("rst_ovr", {31'b0, bus.ovr_err}, 32'h0);
    rst = 1'b1;
    tick(2);

    // Nominal with busy window
    check("busy_c0", {31'b0, bus.busy}, 32'h0);
    start(0, 1'b1);
    check("busy_c1", {31'b0, bus.busy}, 32'h1);
    tick(20);
    check("busy_c21", {31'b0, bus.busy}, 32'h1);
    tick(1);
    check("busy_c22", {31'b0, bus.busy}, 32'h0);
    check("nom_ovr", {31'b0, bus.ovr_err}, 32'h0);
    wait_done(40);

    // Zero exponent term and zero shunt conductance
    start(1, 1'b1);
    wait_done(40);

    // sta coincident with done_sig is dropped, the next cycle is accepted
    start(3, 1'b1);
    check("coin_ovr_before", {31'b0, bus.ovr_err}, 32'h0);
    tick(21);
    start(4, 1'b0);
    start(4, 1'b1);
    check("coin_ovr_after", {31'b0, bus.ovr_err}, 32'h1);
    wait_done(60);

    // Asynchronous reset mid-operation
    start(2, 1'b0);
    tick(7);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_Id", bus.Id, 32'h0);
    check("mid_rst_Ipv", bus.Ipv, 32'h0);
    check("mid_rst_busy", {31'b0, bus.busy}, 32'h0);
    check("mid_rst_ovr", {31'b0, bus.ovr_err}, 32'h0);
    tick(2);
    rst = 1'b1;
    tick(30);
    check("post_rst_busy", {31'b0, bus.busy}, 32'h0);
    start(6, 1'b1);
    wait_done(40);

    // Overrun: second sta at cycle 10 is ignored, first result stands
    start(0, 1'b1);
    tick(9);
    start(2, 1'b0);
    check("ovr_set", {31'b0, bus.ovr_err}, 32'h1);
    check("ovr_busy", {31'b0, bus.busy}, 32'h1);
    wait_done(40);
    tick(10);
    start(5, 1'b1);
    wait_done(40);
    check("ovr_sticky", {31'b0, bus.ovr_err}, 32'h1);

    // Back-to-back chain, sta every 23 cycles
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    for (int i = 2; i < 7; i++) begin
      start(i, 1'b1);
      tick(22);
    end
    wait_done(40);
    check("chain_ovr", {31'b0, bus.ovr_err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
